// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t     - converter FSM states
//   NIB_THRESH  - nibble value at and above which the add-3 correction applies
//   NIB_CORR    - add-3 correction value
//   bcd_max()   - largest value representable in a given number of BCD digits
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [3:0] NIB_THRESH = 4'd5;
   localparam logic [3:0] NIB_CORR   = 4'd3;

   // 10^digits - 1, evaluated at elaboration time.
   function automatic longint unsigned bcd_max(input int digits);
      longint unsigned m;
      m = 64'd1;
      for (int i = 0; i < digits; i++) begin
         m = m * 64'd10;
      end
      return m - 64'd1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One BCD digit pre-shift correction: nibble >= 5 gets +3 (4-bit, carry dropped).
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   nib - scratch nibble before the shift
//   adj - corrected nibble
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [3:0] nib,
   output logic [3:0] adj
);

   // Plain 4-bit add: any carry out is meaningless for a valid BCD digit
   // in range and is deliberately discarded.
   assign adj = (nib >= NIB_THRESH) ? (nib + NIB_CORR) : nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter, shift-and-add-3, one bit per clock.
// Latency: done pulses in the cycle after edge E0+WIDTH+1 (E0 = accepting edge); 18-cycle throughput.
// Backpressure: start is only accepted while idle; requests while busy are dropped, not queued.
//
// Ports:
//   clk   - system clock, all state on rising edge
//   rst   - asynchronous active-high reset; aborts a conversion with no done
//   start - conversion request, sampled only in IDLE
//   bin   - unsigned binary input, sampled on the accepting edge only
//   bcd   - packed BCD result (digit 0 in [3:0]); holds last result
//   busy  - high while a conversion is in progress
//   done  - one-cycle pulse when bcd/ovf are updated
//   ovf   - last result saturated to all nines (bin > 10^DIGITS-1)
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf
);

   localparam int              BW  = 4 * DIGITS;
   localparam int              CW  = $clog2(WIDTH + 1);
   localparam longint unsigned MAX = bcd_max(DIGITS);

   // WIDTH must be able to hold every value up to MAX, otherwise the
   // saturation compare and the digit count disagree.
   if (WIDTH < $clog2(MAX + 64'd1)) begin : g_width_check
      $error("bin2bcd_seq: WIDTH %0d too small for %0d BCD digits", WIDTH, DIGITS);
   end

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [BW-1:0]    scratch_q;
   logic [BW-1:0]    scratch_adj;
   logic [CW-1:0]    cnt_q;
   logic             sat_q;

   // Per-digit add-3 on the pre-edge scratch value.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adj u_adj (
         .nib (scratch_q[4*g +: 4]),
         .adj (scratch_adj[4*g +: 4])
      );
   end

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // cnt_q == 1 means this edge performs the final shift.
            if (cnt_q == CW'(1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath and registered outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         bcd       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  shreg_q   <= bin;
                  scratch_q <= '0;
                  cnt_q     <= CW'(WIDTH);
                  // Saturation decided once from the latched value.
                  sat_q     <= (64'(bin) > MAX);
                  busy      <= 1'b1;
               end
            end
            SHIFT: begin
               // {scratch, shreg} << 1 using the corrected scratch; the cast
               // drops the carry out of the top digit, which only matters
               // for values that saturate anyway.
               scratch_q <= BW'({scratch_adj, shreg_q[WIDTH-1]});
               shreg_q   <= shreg_q << 1;
               cnt_q     <= cnt_q - CW'(1);
            end
            FINISH: begin
               bcd  <= sat_q ? {DIGITS{4'h9}} : scratch_q;
               ovf  <= sat_q;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=16, DIGITS=4).
// Inputs driven #1 after the rising edge, outputs sampled at the same point.
// Every comparison is an immediate assertion counted in n_vec / n_err.
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] bin;
   logic [15:0] bcd;
   logic        busy;
   logic        done;
   logic        ovf;

   int          n_vec;
   int          n_err;
   logic [15:0] prev_bcd;

   bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .bcd   (bcd),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One conversion: accept v, optionally re-pulse start (bin=777) after
   // busy cycle restart_at, then watch 40 cycles for exactly one done.
   task automatic do_conv(input string tag, input logic [15:0] v, input logic [15:0] eb,
                          input logic eo, input int restart_at);
      int first;
      int cnt;
      first = -1;
      cnt   = 0;
      @(posedge clk); #1;
      start = 1'b1;
      bin   = v;
      @(posedge clk); #1;               // accepting edge E0
      start = 1'b0;
      bin   = 16'hA5A5;                 // must not affect the result
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == restart_at) begin
            start = 1'b1;
            bin   = 16'd777;
         end else if (n == restart_at + 1) begin
            start = 1'b0;
         end
         if (n == 1) chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
         if (n == 16) begin
            chk({tag, "_busy_c16"}, 32'(busy), 32'd1);
            chk({tag, "_bcd_held"}, 32'(bcd), 32'(prev_bcd));
         end
         if (done) begin
            cnt++;
            if (first < 0) begin
               first = n;
               chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
               chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
               chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            end
         end
      end
      chk({tag, "_latency"}, 32'(first), 32'd17);
      chk({tag, "_done_cnt"}, 32'(cnt), 32'd1);
      prev_bcd = eb;
   endtask

   initial begin
      int d1;
      int d2;
      int extra;
      n_vec    = 0;
      n_err    = 0;
      prev_bcd = 16'h0000;
      rst      = 1'b1;
      start    = 1'b0;
      bin      = 16'd0;

      // Reset state
      #12;
      chk("rst_bcd",  32'(bcd),  32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_ovf",  32'(ovf),  32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic conversions and saturation boundaries
      do_conv("zero",  16'd0,     16'h0000, 1'b0, -1);
      do_conv("v1234", 16'd1234,  16'h1234, 1'b0, -1);
      do_conv("v9999", 16'd9999,  16'h9999, 1'b0, -1);
      do_conv("v10000",16'd10000, 16'h9999, 1'b1, -1);
      do_conv("v65535",16'd65535, 16'h9999, 1'b1, -1);
      do_conv("v42",   16'd42,    16'h0042, 1'b0, -1);

      // start while busy is ignored
      do_conv("v500",  16'd500,   16'h0500, 1'b0, 5);

      // Async reset in the middle of a conversion of 4321
      @(posedge clk); #1;
      start = 1'b1;
      bin   = 16'd4321;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_bcd",  32'(bcd),  32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_ovf",  32'(ovf),  32'h0);
      chk("arst_done", 32'(done), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("arst_hold_done", 32'(done), 32'h0);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      prev_bcd = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) chk("arst_no_done", 32'(done), 32'h0);
      end
      do_conv("v86", 16'd86, 16'h0086, 1'b0, -1);

      // Back-to-back with start held high
      d1    = -1;
      d2    = -1;
      extra = 0;
      @(posedge clk); #1;
      start = 1'b1;
      bin   = 16'd7;
      @(posedge clk); #1;               // E0 accepts 7
      bin   = 16'd8;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (n == 18) start = 1'b0;     // second request accepted at E18
         if (done) begin
            if (d1 < 0) begin
               d1 = n;
               chk("b2b_bcd0", 32'(bcd), 32'h0007);
            end else if (d2 < 0) begin
               d2 = n;
               chk("b2b_bcd1", 32'(bcd), 32'h0008);
            end else begin
               extra++;
            end
         end
      end
      chk("b2b_first",  32'(d1),      32'd17);
      chk("b2b_spacing",32'(d2 - d1), 32'd18);
      chk("b2b_extra",  32'(extra),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
